// File: rtl/ed25519_pkg.sv
// ed25519_pkg: shared constants and FSM state type for the scalar-multiply buffer controller.
package ed25519_pkg;
    localparam int ED_WORDS = 8;
    localparam int ED_AW    = 3;
    localparam int ED_DW    = 32;
    typedef enum logic [2:0] {IDLE, ARM, WAIT_LO, WAIT_HI, DONE} state_t;
endpackage

// File: rtl/ed25519_wbuf.sv
// ed25519_wbuf: WORDS x DW register file, one write port, one registered read port, sync clear.
module ed25519_wbuf
    import ed25519_pkg::*;
#(
    parameter int WORDS = ED_WORDS,
    parameter int AW    = ED_AW,
    parameter int DW    = ED_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [WORDS];

    // clear outranks a write landing in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
            if (clr) for (int i = 0; i < WORDS; i++) mem[i] <= '0;
            else if (we) mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/ed25519_mul_buf_ctrl.sv
// ed25519_mul_buf_ctrl: host-side k/qy buffers and start/completion sequencing
// for the scalar-multiply core's memory interface.
module ed25519_mul_buf_ctrl
    import ed25519_pkg::*;
#(
    parameter int WORDS     = ED_WORDS,
    parameter int AW        = ED_AW,
    parameter int DW        = ED_DW,
    parameter bit ZEROIZE_K = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             h_wr_en,
    input  logic [AW-1:0]    h_wr_addr,
    input  logic [DW-1:0]    h_wr_data,
    input  logic             h_start,
    input  logic             h_clr,
    input  logic [AW-1:0]    h_rd_addr,
    output logic [DW-1:0]    h_rd_data,
    output logic             h_busy,
    output logic             h_done,
    output logic             h_err,
    output logic [WORDS-1:0] h_qy_valid,
    output logic             core_ena,
    input  logic             core_rdy,
    input  logic [AW-1:0]    k_addr,
    output logic [DW-1:0]    k_din,
    input  logic [AW-1:0]    qy_addr,
    input  logic             qy_wren,
    input  logic [DW-1:0]    qy_dout
);
    state_t state, state_nx;
    logic   cap, host_ok, finish;

    assign h_busy   = state == ARM || state == WAIT_LO || state == WAIT_HI;
    assign cap      = state == WAIT_LO || state == WAIT_HI;
    assign host_ok  = state == IDLE || state == DONE;
    assign finish   = state == WAIT_HI && core_rdy;
    assign core_ena = state == ARM;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = h_start && !h_clr ? ARM : IDLE;
            ARM:     state_nx = WAIT_LO;
            WAIT_LO: state_nx = core_rdy ? WAIT_LO : WAIT_HI;
            WAIT_HI: state_nx = core_rdy ? DONE : WAIT_HI;
            DONE:    state_nx = h_clr ? IDLE : h_start ? ARM : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // h_clr wins over error sources raised in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            h_done     <= 1'b0;
            h_err      <= 1'b0;
            h_qy_valid <= '0;
        end else begin
            state      <= state_nx;
            h_done     <= finish || (h_done && !h_clr && state != ARM);
            h_err      <= !h_clr && (h_err || (h_busy && (h_wr_en || h_start)) || (qy_wren && host_ok));
            h_qy_valid <= (state == ARM || h_clr ? '0 : h_qy_valid)
                        | (qy_wren && cap ? WORDS'(1) << qy_addr : '0);
        end
    end

    ed25519_wbuf #(.WORDS(WORDS), .AW(AW), .DW(DW)) u_kbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ZEROIZE_K && finish),
        .we    (h_wr_en && host_ok),
        .waddr (h_wr_addr),
        .wdata (h_wr_data),
        .raddr (k_addr),
        .rdata (k_din)
    );

    ed25519_wbuf #(.WORDS(WORDS), .AW(AW), .DW(DW)) u_qybuf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .we    (qy_wren && cap),
        .waddr (qy_addr),
        .wdata (qy_dout),
        .raddr (h_rd_addr),
        .rdata (h_rd_data)
    );
endmodule

// File: tb/tb_ed25519_mul_buf_ctrl.sv
// tb_ed25519_mul_buf_ctrl: directed + randomized checks of the buffer controller
// against a word-array model of the k/qy buffers and host flags.
module tb_ed25519_mul_buf_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        h_wr_en = 0, h_start = 0, h_clr = 0, core_rdy = 1, qy_wren = 0;
    logic [2:0]  h_wr_addr = 0, h_rd_addr = 0, k_addr = 0, qy_addr = 0;
    logic [31:0] h_wr_data = 0, qy_dout = 0, h_rd_data, k_din;
    logic        h_busy, h_done, h_err, core_ena;
    logic [7:0]  h_qy_valid;

    int          checks = 0, passed = 0, ena_cnt = 0, ena_base;
    logic [31:0] km [8];
    logic [31:0] qm [8];
    logic [7:0]  qv;

    ed25519_mul_buf_ctrl dut (
        .clk(clk), .rst_n(rst_n), .h_wr_en(h_wr_en), .h_wr_addr(h_wr_addr),
        .h_wr_data(h_wr_data), .h_start(h_start), .h_clr(h_clr), .h_rd_addr(h_rd_addr),
        .h_rd_data(h_rd_data), .h_busy(h_busy), .h_done(h_done), .h_err(h_err),
        .h_qy_valid(h_qy_valid), .core_ena(core_ena), .core_rdy(core_rdy), .k_addr(k_addr),
        .k_din(k_din), .qy_addr(qy_addr), .qy_wren(qy_wren), .qy_dout(qy_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (core_ena) ena_cnt <= ena_cnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic kwrite(input int a, input logic [31:0] d);
        h_wr_en = 1; h_wr_addr = 3'(a); h_wr_data = d;
        tick;
        h_wr_en = 0;
    endtask

    task automatic qwrite(input int a, input logic [31:0] d);
        qy_wren = 1; qy_addr = 3'(a); qy_dout = d;
        tick;
        qy_wren = 0;
        qm[a] = d;
        qv[a] = 1'b1;
    endtask

    // start from IDLE/DONE and walk the core handshake into WAIT_HI
    task automatic launch;
        ena_base = ena_cnt;
        h_start = 1;
        tick;
        h_start = 0;
        chk("ena_in_arm", {31'b0, core_ena}, 1);
        chk("busy_in_arm", {31'b0, h_busy}, 1);
        tick;
        chk("ena_one_cycle", {31'b0, core_ena}, 0);
        tick;
        core_rdy = 0;
        tick;
        qv = '0;
    endtask

    task automatic verify_k;
        for (int i = 0; i < 8; i++) begin
            k_addr = 3'(i);
            tick;
            chk($sformatf("k_din[%0d]", i), k_din, km[i]);
        end
    endtask

    task automatic verify_qy;
        for (int i = 0; i < 8; i++) begin
            h_rd_addr = 3'(i);
            tick;
            chk($sformatf("qy_rd[%0d]", i), h_rd_data, qm[i]);
        end
    endtask

    initial begin
        logic [31:0] r;
        int a;
        for (int i = 0; i < 8; i++) begin km[i] = 0; qm[i] = 0; end
        qv = '0;
        #3;
        chk("rst_busy", {31'b0, h_busy}, 0);
        chk("rst_done", {31'b0, h_done}, 0);
        chk("rst_err", {31'b0, h_err}, 0);
        chk("rst_qv", {24'b0, h_qy_valid}, 0);
        chk("rst_ena", {31'b0, core_ena}, 0);
        chk("rst_kdin", k_din, 0);
        chk("rst_rd", h_rd_data, 0);
        #4 rst_n = 1;
        tick;

        // directed operation: k = 0x11111111*i, qy = 0xA5000000+i
        for (int i = 0; i < 8; i++) begin
            km[i] = 32'h11111111 * i;
            kwrite(i, km[i]);
        end
        launch;
        verify_k;
        for (int i = 0; i < 8; i++) qwrite(i, 32'hA5000000 + i);
        r = $urandom;
        h_wr_en = 1; h_wr_addr = 2; h_wr_data = r; h_start = 1;
        tick;
        h_wr_en = 0; h_start = 0;
        chk("err_busy_wr_start", {31'b0, h_err}, 1);
        k_addr = 2;
        tick;
        chk("k2_unchanged", k_din, km[2]);
        core_rdy = 1;
        tick;
        for (int i = 0; i < 8; i++) km[i] = 0;
        chk("done_set", {31'b0, h_done}, 1);
        chk("qv_full", {24'b0, h_qy_valid}, 32'hFF);
        chk("busy_off", {31'b0, h_busy}, 0);
        chk("single_ena", ena_cnt - ena_base, 1);
        h_rd_addr = 3;
        tick;
        chk("qy3", h_rd_data, 32'hA5000003);
        verify_k;
        h_clr = 1;
        tick;
        h_clr = 0;
        chk("clr_err", {31'b0, h_err}, 0);
        chk("clr_done", {31'b0, h_done}, 0);
        chk("clr_qv", {24'b0, h_qy_valid}, 0);

        // randomized operation with a last-write-wins case on word 5
        for (int i = 0; i < 8; i++) begin
            km[i] = $urandom;
            kwrite(i, km[i]);
        end
        launch;
        verify_k;
        for (int n = 0; n < 6; n++) begin
            a = int'($urandom_range(0, 7));
            qwrite(a, $urandom);
        end
        qwrite(5, 32'h1);
        qwrite(5, 32'h2);
        chk("busy_wait", {31'b0, h_busy}, 1);
        core_rdy = 1;
        tick;
        for (int i = 0; i < 8; i++) km[i] = 0;
        chk("done_set2", {31'b0, h_done}, 1);
        chk("qv_mask", {24'b0, h_qy_valid}, {24'b0, qv});
        chk("err_clean", {31'b0, h_err}, 0);
        verify_qy;
        verify_k;

        // start+clr together in DONE: clr wins
        ena_base = ena_cnt;
        h_start = 1; h_clr = 1;
        tick;
        h_start = 0; h_clr = 0;
        tick;
        chk("sc_busy", {31'b0, h_busy}, 0);
        chk("sc_done", {31'b0, h_done}, 0);
        chk("sc_no_ena", ena_cnt - ena_base, 0);

        // spurious core write while idle
        qy_wren = 1; qy_addr = 1; qy_dout = 32'hDEADBEEF;
        tick;
        qy_wren = 0;
        chk("spur_err", {31'b0, h_err}, 1);
        h_rd_addr = 1;
        tick;
        chk("spur_ignored", h_rd_data, qm[1]);
        h_clr = 1;
        tick;
        h_clr = 0;
        chk("spur_clr", {31'b0, h_err}, 0);

        // async reset in ARM, then in WAIT_LO
        h_start = 1;
        tick;
        h_start = 0;
        chk("arm_ena", {31'b0, core_ena}, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_arm_ena", {31'b0, core_ena}, 0);
        chk("rst_arm_busy", {31'b0, h_busy}, 0);
        #2 rst_n = 1;
        tick;
        kwrite(4, $urandom);
        h_start = 1;
        tick;
        h_start = 0;
        tick;
        chk("wlo_busy", {31'b0, h_busy}, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_wlo_busy", {31'b0, h_busy}, 0);
        chk("rst_wlo_ena", {31'b0, core_ena}, 0);
        chk("rst_wlo_done", {31'b0, h_done}, 0);
        #2 rst_n = 1;
        for (int i = 0; i < 8; i++) begin km[i] = 0; qm[i] = 0; end
        tick;
        verify_k;
        verify_qy;
        chk("post_rst_qv", {24'b0, h_qy_valid}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
